encoder42_rr_arbiter: RTL and testbench



---
 rtl/encoder42_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_encoder42_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder42_rr_arbiter.sv
// encoder42_rr_arbiter: four-way round-robin arbiter, registered one-hot + encoded grant.
// Define ARB_HOLD_TIMEOUT_EN to enable the HOLD_MAX hold-limit revoke and timeout pulse.
module encoder42_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       rel,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_v,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] ptr_q, ptr_d;

    logic [6:0] req_dup;
    logic [3:0] req_rot;
    logic [1:0] off;
    logic [1:0] sel;
    logic [3:0] sel_oh;
    logic       own_req;
    logic       limit;
    logic       end_grant;

    if (HOLD_MAX < 1 || HOLD_MAX > 255 || HOLD_MAX >= (1 << CNT_W)) begin : g_bad_cfg
        $error("encoder42_rr_arbiter: illegal HOLD_MAX/CNT_W combination");
    end

    // Rotate requests so bit 0 is the requester the pointer favours.
    assign req_dup = {req[2:0], req};
    assign req_rot = req_dup[ptr_q +: 4];

    always_comb begin
        off = 2'd0;
        priority case (1'b1)
            req_rot[0]: off = 2'd0;
            req_rot[1]: off = 2'd1;
            req_rot[2]: off = 2'd2;
            req_rot[3]: off = 2'd3;
            default:    off = 2'd0;
        endcase
    end

    assign sel = ptr_q + off;

    always_comb begin
        sel_oh = 4'b0000;
        unique case (sel)
            2'd0: sel_oh = 4'b0001;
            2'd1: sel_oh = 4'b0010;
            2'd2: sel_oh = 4'b0100;
            2'd3: sel_oh = 4'b1000;
            default: sel_oh = 4'b0000;
        endcase
    end

    assign own_req   = req[idx_q];
    assign end_grant = rel || !own_req || limit;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(HOLD_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q;

    assign limit = (state_q == GRANT) && (cnt_q == CNT_LIM);

    always_comb begin
        cnt_d = '0;
        if (state_q == GRANT) begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= limit && !rel && own_req;
        end
    end

    assign timeout = to_q;
`else
    assign limit   = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = sel_oh;
                    idx_d   = sel;
                end
            end
            GRANT: begin
                if (end_grant) begin
                    state_d = GAP;
                    gnt_d   = 4'b0000;
                    ptr_d   = idx_q + 2'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            idx_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_v   = |gnt_q;

endmodule

// File: tb/tb_encoder42_rr_arbiter.sv
// tb_encoder42_rr_arbiter: directed table, corner sequences and random run
// against a behavioural round-robin model.
module tb_encoder42_rr_arbiter;

    localparam int HOLD = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       rel = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_v;
    logic       timeout;

    int n_pass = 0;
    int n_total = 0;

    encoder42_rr_arbiter #(
        .HOLD_MAX(HOLD),
        .CNT_W   (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .rel    (rel),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .gnt_v  (gnt_v),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Model: owner (-1 = none), a one-cycle gap flag, pointer, cycles held.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_idx   = 0;
    bit m_to    = 1'b0;

    task automatic model_step(input bit r, input logic [3:0] q, input bit l);
        bit hit;
        bit found;
        int c;
        if (!r) begin
            m_owner = -1;
            m_gap   = 1'b0;
            m_ptr   = 0;
            m_held  = 0;
            m_idx   = 0;
            m_to    = 1'b0;
        end else if (m_owner >= 0) begin
            m_held = m_held + 1;
            m_to   = 1'b0;
            hit    = TO_EN && (m_held >= HOLD);
            if (l || !q[m_owner] || hit) begin
                m_to    = hit && !l && q[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
            m_to  = 1'b0;
        end else begin
            m_to  = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (!found && q[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_idx   = c;
                    m_held  = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Apply inputs, step model, clock, then compare all outputs to the model.
    task automatic tick(input bit r, input logic [3:0] q, input bit l);
        logic [3:0] eg;
        logic [7:0] exp_all;
        rst_n = r;
        req   = q;
        rel   = l;
        model_step(r, q, l);
        @(posedge clk);
        #1;
        eg      = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        exp_all = {eg, m_idx[1:0], (m_owner >= 0), m_to};
        check("model", {24'd0, gnt, gnt_idx, gnt_v, timeout}, {24'd0, exp_all});
    endtask

    typedef struct {
        bit         r;
        logic [3:0] q;
        bit         l;
        logic [3:0] g;
        logic [1:0] idx;
        bit         v;
        bit         to;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input logic [3:0] q, input bit l,
                       input logic [3:0] g, input logic [1:0] idx, input bit v);
        vec_t x;
        x.r   = r;
        x.q   = q;
        x.l   = l;
        x.g   = g;
        x.idx = idx;
        x.v   = v;
        x.to  = 1'b0;
        vecs.push_back(x);
    endtask

    task automatic outs(input string name, input logic [3:0] g, input logic [1:0] idx,
                        input bit v, input bit to);
        check(name, {24'd0, gnt, gnt_idx, gnt_v, timeout}, {24'd0, g, idx, v, to});
    endtask

    int run_v;
    int run_to;
    int rq;

    initial begin
        add(0, 4'b1111, 0, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 0, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 0, 4'b0000, 2'd0, 0);
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0);
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0);
        add(1, 4'b0100, 0, 4'b0100, 2'd2, 1);
        add(1, 4'b0100, 0, 4'b0100, 2'd2, 1);
        add(1, 4'b0100, 0, 4'b0100, 2'd2, 1);
        add(1, 4'b0100, 1, 4'b0000, 2'd2, 0);
        add(1, 4'b0100, 0, 4'b0000, 2'd2, 0);
        add(1, 4'b0100, 0, 4'b0100, 2'd2, 1);
        add(1, 4'b0000, 0, 4'b0000, 2'd2, 0);
        add(1, 4'b0000, 0, 4'b0000, 2'd2, 0);
        add(1, 4'b0011, 0, 4'b0001, 2'd0, 1);
        add(1, 4'b0011, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b0011, 0, 4'b0000, 2'd0, 0);
        add(1, 4'b0011, 0, 4'b0010, 2'd1, 1);
        add(1, 4'b0011, 1, 4'b0000, 2'd1, 0);
        add(1, 4'b0011, 0, 4'b0000, 2'd1, 0);
        add(1, 4'b0011, 0, 4'b0001, 2'd0, 1);
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0);
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            tick(vecs[i].r, vecs[i].q, vecs[i].l);
            outs($sformatf("vec%0d", i), vecs[i].g, vecs[i].idx, vecs[i].v, vecs[i].to);
        end

        // Fairness: order 0,1,2,3,0 with two dead cycles between owners.
        tick(0, 4'b1111, 0);
        for (int k = 0; k < 5; k++) begin
            tick(1, 4'b1111, 0);
            outs($sformatf("rr_gnt%0d", k), 4'b0001 << (k % 4), 2'(k % 4), 1, 0);
            tick(1, 4'b1111, 1);
            outs($sformatf("rr_gap%0d", k), 4'b0000, 2'(k % 4), 0, 0);
            tick(1, 4'b1111, 0);
            outs($sformatf("rr_idle%0d", k), 4'b0000, 2'(k % 4), 0, 0);
        end

        // Hold limit with a single persistent requester.
        tick(0, 4'b0000, 0);
        run_v  = 0;
        run_to = 0;
        if (TO_EN) begin
            for (int k = 0; k < HOLD; k++) begin
                tick(1, 4'b0001, 0);
                if (gnt_v) run_v++;
            end
            check("hold_cycles", run_v, HOLD);
            tick(1, 4'b0001, 0);
            outs("timeout_pulse", 4'b0000, 2'd0, 0, 1);
            tick(1, 4'b0001, 0);
            outs("timeout_clear", 4'b0000, 2'd0, 0, 0);
        end else begin
            for (int k = 0; k < 100; k++) begin
                tick(1, 4'b0001, 0);
                if (gnt_v) run_v++;
                if (timeout) run_to++;
            end
            check("hold_forever", run_v, 100);
            check("no_timeout", run_to, 0);
        end

        // Release on the limit cycle: release wins, no timeout pulse.
        tick(0, 4'b0000, 0);
        for (int k = 0; k < HOLD; k++) tick(1, 4'b0001, 0);
        outs("limit_cycle", 4'b0001, 2'd0, 1, 0);
        tick(1, 4'b0001, 1);
        outs("rel_on_limit", 4'b0000, 2'd0, 0, 0);

        // Reset mid-grant, then pointer restarts at 0.
        tick(0, 4'b0000, 0);
        tick(1, 4'b1000, 0);
        outs("gnt3", 4'b1000, 2'd3, 1, 0);
        tick(0, 4'b1111, 0);
        outs("rst_mid", 4'b0000, 2'd0, 0, 0);
        tick(1, 4'b1111, 0);
        outs("after_rst", 4'b0001, 2'd0, 1, 0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rq = $urandom_range(0, 3);
            tick(($urandom_range(0, 63) != 0),
                 (rq == 0) ? 4'($urandom_range(0, 15)) : req | 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 5) == 0));
            if (gnt_v && gnt != (4'b0001 << gnt_idx))
                check("onehot", {28'd0, gnt}, {28'd0, 4'b0001 << gnt_idx});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
